// File: rtl/br_fifo_shared_read_stage.sv
// Pop-side read stage of a shared multi-FIFO: issues RAM reads for head
// addresses, stages the in-order returning data and reports issued addresses.
module br_fifo_shared_read_stage #(
    parameter int Depth          = 2,
    parameter int RamReadLatency = 0,
    parameter int AddrWidth      = 1,
    parameter int Width          = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         head_valid,
    output logic                         head_ready,
    input  logic [AddrWidth-1:0]         head_addr,
    output logic                         rd_addr_valid,
    input  logic                         rd_addr_ready,
    output logic [AddrWidth-1:0]         rd_addr,
    input  logic                         rd_data_valid,
    input  logic [Width-1:0]             rd_data,
    output logic                         pop_valid,
    input  logic                         pop_ready,
    output logic [Width-1:0]             pop_data,
    output logic                         dealloc_valid,
    output logic [AddrWidth-1:0]         dealloc_addr,
    output logic [$clog2(Depth+1)-1:0]   occupancy
);

    localparam int CountWidth = $clog2(Depth + 1);
    localparam int PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);
    localparam logic [PtrWidth-1:0]   LastPtr    = PtrWidth'(Depth - 1);

    logic [CountWidth-1:0] reserved;
    logic [CountWidth-1:0] stored;
    logic [CountWidth-1:0] inflight;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [Width-1:0]      mem [Depth];
    logic                  slot_avail;
    logic                  rd_hs;
    logic                  pop_hs;

    // A pop frees its slot only from the next cycle; slot_avail uses the registered count.
    assign slot_avail    = reserved < DepthCount;
    assign rd_addr_valid = head_valid & slot_avail;
    assign head_ready    = rd_addr_ready & slot_avail;
    assign rd_addr       = head_addr;
    assign rd_hs         = rd_addr_valid & rd_addr_ready;

    assign pop_valid = stored != '0;
    assign pop_data  = mem[rd_ptr];
    assign pop_hs    = pop_valid & pop_ready;
    assign occupancy = reserved;
    assign inflight  = reserved - stored;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reserved <= '0;
        end else if (rd_hs && !pop_hs) begin
            reserved <= reserved + CountWidth'(1);
        end else if (!rd_hs && pop_hs) begin
            reserved <= reserved - CountWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stored <= '0;
        end else if (rd_data_valid && !pop_hs) begin
            stored <= stored + CountWidth'(1);
        end else if (!rd_data_valid && pop_hs) begin
            stored <= stored - CountWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rd_data_valid) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (pop_hs) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_data_valid) begin
            mem[wr_ptr] <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dealloc_valid <= 1'b0;
            dealloc_addr  <= '0;
        end else begin
            dealloc_valid <= rd_hs;
            if (rd_hs) begin
                dealloc_addr <= head_addr;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!rd_data_valid || rd_hs || inflight != '0)
                else $error("rd_data_valid with no read in flight");
            assert (!rd_data_valid || pop_hs || stored != DepthCount)
                else $error("staging buffer overflow");
        end
    end
`endif

endmodule

// File: tb/tb_br_fifo_shared_read_stage.sv
// Bench for br_fifo_shared_read_stage: a table-driven Depth=1/latency-0 instance
// and a Depth=3/latency-1 instance checked against a queue-based reference model.
module tb_br_fifo_shared_read_stage;

    localparam int DA = 3;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: Depth=3, RamReadLatency=1
    logic       rst_a, hv_a, hr_a, rav_a, rar_a, rdv_a, pv_a, pr_a, dv_a;
    logic [3:0] ha_a, raddr_a, da_a;
    logic [7:0] rdd_a, pd_a;
    logic [1:0] occ_a;

    // Instance B: Depth=1, RamReadLatency=0
    logic       rst_b, hv_b, hr_b, rav_b, rar_b, rdv_b, pv_b, pr_b, dv_b;
    logic [3:0] ha_b, raddr_b, da_b;
    logic [7:0] rdd_b, pd_b;
    logic [0:0] occ_b;

    br_fifo_shared_read_stage #(
        .Depth(DA), .RamReadLatency(1), .AddrWidth(4), .Width(8)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_a),
        .head_valid(hv_a), .head_ready(hr_a), .head_addr(ha_a),
        .rd_addr_valid(rav_a), .rd_addr_ready(rar_a), .rd_addr(raddr_a),
        .rd_data_valid(rdv_a), .rd_data(rdd_a),
        .pop_valid(pv_a), .pop_ready(pr_a), .pop_data(pd_a),
        .dealloc_valid(dv_a), .dealloc_addr(da_a), .occupancy(occ_a)
    );

    br_fifo_shared_read_stage #(
        .Depth(1), .RamReadLatency(0), .AddrWidth(4), .Width(8)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b),
        .head_valid(hv_b), .head_ready(hr_b), .head_addr(ha_b),
        .rd_addr_valid(rav_b), .rd_addr_ready(rar_b), .rd_addr(raddr_b),
        .rd_data_valid(rdv_b), .rd_data(rdd_b),
        .pop_valid(pv_b), .pop_ready(pr_b), .pop_data(pd_b),
        .dealloc_valid(dv_b), .dealloc_addr(da_b), .occupancy(occ_b)
    );

    // RAM models: data = 0xA0 + address, crossbar reset together with the stage
    always_ff @(posedge clk) begin
        if (!rst_a) begin
            rdv_a <= 1'b0;
            rdd_a <= 8'h00;
        end else begin
            rdv_a <= rav_a && rar_a;
            rdd_a <= 8'hA0 + {4'h0, raddr_a};
        end
    end
    assign rdv_b = rav_b & rar_b;
    assign rdd_b = 8'hA0 + {4'h0, raddr_b};

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         n_issued = 0;
    int         n_dealloc = 0;
    int         first_hs, first_pv;
    logic [7:0] q_data[$];
    int         q_vis[$];
    logic [7:0] dut_popped[$];
    logic       exp_dv = 1'b0;
    logic [3:0] exp_da = 4'h0;
    logic       last_hs = 1'b0;
    logic [3:0] next_addr = 4'h0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // One cycle of instance A: compare against the model, then advance the model.
    task automatic step_a();
        logic exp_hr, exp_rav, exp_pv, hs, ph;
        @(negedge clk);
        exp_hr  = rar_a && (q_data.size() < DA);
        exp_rav = hv_a && (q_data.size() < DA);
        exp_pv  = (q_data.size() > 0) && (q_vis[0] <= cyc);
        chk("a_head_ready", hr_a, exp_hr);
        chk("a_rd_addr_valid", rav_a, exp_rav);
        if (exp_rav) chk("a_rd_addr", raddr_a, ha_a);
        chk("a_pop_valid", pv_a, exp_pv);
        if (exp_pv) chk("a_pop_data", pd_a, q_data[0]);
        chk("a_occupancy", occ_a, q_data.size());
        chk("a_dealloc_valid", dv_a, exp_dv);
        if (exp_dv) chk("a_dealloc_addr", da_a, exp_da);
        if (dv_a) n_dealloc++;
        if (pv_a && pr_a) dut_popped.push_back(pd_a);
        if (pv_a && first_pv < 0) first_pv = cyc;
        hs = hv_a && exp_hr;
        ph = pr_a && exp_pv;
        if (!rst_a) begin
            hs = 1'b0;
            q_data.delete();
            q_vis.delete();
            exp_dv = 1'b0;
        end else begin
            if (ph) begin
                void'(q_data.pop_front());
                void'(q_vis.pop_front());
            end
            if (hs) begin
                q_data.push_back(8'hA0 + {4'h0, ha_a});
                q_vis.push_back(cyc + 2);
                n_issued++;
                if (first_hs < 0) first_hs = cyc;
            end
            exp_dv = hs;
            exp_da = ha_a;
        end
        last_hs = hs;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic hv, input logic ardy, input logic pr);
        hv_a  = hv;
        ha_a  = next_addr;
        rar_a = ardy;
        pr_a  = pr;
        step_a();
        if (last_hs) next_addr = next_addr + 4'd1;
    endtask

    typedef struct {
        logic       hv;
        logic [3:0] addr;
        logic       ardy;
        logic       pr;
        logic       hr;
        logic       rav;
        logic       pv;
        logic [7:0] pd;
        logic       occ;
        logic       dv;
        logic [3:0] da;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, d0;
        logic [3:0] start;
        //          hv addr  ardy pr | hr rav pv pd     occ dv da
        vecs[0]  = '{1, 4'd1, 1, 0,   1, 1, 0, 8'h00, 0, 0, 4'd0};
        vecs[1]  = '{1, 4'd2, 1, 0,   0, 0, 1, 8'hA1, 1, 1, 4'd1};
        vecs[2]  = '{1, 4'd2, 1, 1,   0, 0, 1, 8'hA1, 1, 0, 4'd0};
        vecs[3]  = '{1, 4'd2, 1, 0,   1, 1, 0, 8'h00, 0, 0, 4'd0};
        vecs[4]  = '{1, 4'd3, 1, 1,   0, 0, 1, 8'hA2, 1, 1, 4'd2};
        vecs[5]  = '{1, 4'd3, 1, 0,   1, 1, 0, 8'h00, 0, 0, 4'd0};
        vecs[6]  = '{1, 4'd4, 1, 1,   0, 0, 1, 8'hA3, 1, 1, 4'd3};
        vecs[7]  = '{1, 4'd4, 0, 0,   0, 1, 0, 8'h00, 0, 0, 4'd0};
        vecs[8]  = '{1, 4'd4, 1, 1,   1, 1, 0, 8'h00, 0, 0, 4'd0};
        vecs[9]  = '{0, 4'd0, 1, 1,   0, 0, 1, 8'hA4, 1, 1, 4'd4};
        vecs[10] = '{0, 4'd0, 1, 0,   1, 0, 0, 8'h00, 0, 0, 4'd0};

        rst_a = 1'b0; hv_a = 1'b0; ha_a = 4'h0; rar_a = 1'b1; pr_a = 1'b0;
        rst_b = 1'b0; hv_b = 1'b0; ha_b = 4'h0; rar_b = 1'b1; pr_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;

        chk("a_reset_pop_valid", pv_a, 0);
        chk("a_reset_occupancy", occ_a, 0);
        chk("a_reset_dealloc", dv_a, 0);
        chk("a_reset_rd_addr_valid", rav_a, 0);

        // Zero latency, Depth=1, alternating pop_ready
        for (int i = 0; i < 11; i++) begin
            hv_b = vecs[i].hv; ha_b = vecs[i].addr; rar_b = vecs[i].ardy; pr_b = vecs[i].pr;
            @(negedge clk);
            chk("b_head_ready", hr_b, vecs[i].hr);
            chk("b_rd_addr_valid", rav_b, vecs[i].rav);
            if (vecs[i].rav) chk("b_rd_addr", raddr_b, vecs[i].addr);
            chk("b_pop_valid", pv_b, vecs[i].pv);
            if (vecs[i].pv) chk("b_pop_data", pd_b, vecs[i].pd);
            chk("b_occupancy", occ_b, vecs[i].occ);
            chk("b_dealloc_valid", dv_b, vecs[i].dv);
            if (vecs[i].dv) chk("b_dealloc_addr", da_b, vecs[i].da);
            @(posedge clk);
            #1;
        end
        hv_b = 1'b0;

        // Streaming: addresses 0..7 back to back
        rst_a = 1'b1;
        first_hs = -1; first_pv = -1;
        dut_popped.delete();
        next_addr = 4'h0;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 1'b1, 1'b1);
            chk("stream_one_per_cycle", last_hs, 1);
        end
        repeat (4) drive_a(1'b0, 1'b1, 1'b1);
        chk("stream_first_pop_latency", first_pv - first_hs, 2);
        chk("stream_pop_count", dut_popped.size(), 8);
        for (int i = 0; i < 8 && i < dut_popped.size(); i++)
            chk("stream_pop_order", dut_popped[i], 8'hA0 + i);

        // Backpressure to full
        i0 = n_issued;
        repeat (5) drive_a(1'b1, 1'b1, 1'b0);
        chk("full_issued", n_issued - i0, DA);
        hv_a = 1'b1; rar_a = 1'b1; pr_a = 1'b1; ha_a = next_addr;
        #1;
        chk("full_occupancy", occ_a, DA);
        chk("full_head_ready", hr_a, 0);
        drive_a(1'b1, 1'b1, 1'b1);
        chk("full_pop_no_issue", last_hs, 0);
        hv_a = 1'b1; pr_a = 1'b0;
        #1;
        chk("freed_head_ready", hr_a, 1);
        drive_a(1'b1, 1'b1, 1'b0);
        chk("freed_issue", last_hs, 1);
        repeat (6) drive_a(1'b0, 1'b1, 1'b1);

        // Crossbar stall
        d0 = n_dealloc;
        i0 = n_issued;
        repeat (4) drive_a(1'b1, 1'b0, 1'b1);
        chk("stall_no_dealloc", n_dealloc - d0, 0);
        chk("stall_no_issue", n_issued - i0, 0);
        chk("stall_occupancy", occ_a, 0);
        drive_a(1'b1, 1'b1, 1'b1);
        drive_a(1'b0, 1'b1, 1'b1);
        drive_a(1'b0, 1'b1, 1'b1);
        chk("release_issue", n_issued - i0, 1);
        chk("release_dealloc", n_dealloc - d0, 1);
        repeat (3) drive_a(1'b0, 1'b1, 1'b1);

        // Simultaneous issue, return and pop at R=Depth-1, across pointer wrap
        repeat (2) drive_a(1'b1, 1'b1, 1'b0);
        chk("simul_setup_occ", occ_a, DA - 1);
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 1'b1, 1'b1);
            chk("simul_hs", last_hs, 1);
            chk("simul_occ", occ_a, DA - 1);
        end
        repeat (4) drive_a(1'b0, 1'b1, 1'b1);

        // Mid-stream reset
        repeat (2) drive_a(1'b1, 1'b1, 1'b0);
        rst_a = 1'b0;
        drive_a(1'b0, 1'b1, 1'b0);
        rst_a = 1'b1;
        chk("rst_pop_valid", pv_a, 0);
        chk("rst_occupancy", occ_a, 0);
        chk("rst_dealloc", dv_a, 0);
        dut_popped.delete();
        start = next_addr;
        repeat (5) drive_a(1'b1, 1'b1, 1'b1);
        repeat (4) drive_a(1'b0, 1'b1, 1'b1);
        chk("fresh_pop_count", dut_popped.size(), 5);
        for (int i = 0; i < 5 && i < dut_popped.size(); i++)
            chk("fresh_pop_order", dut_popped[i], 8'hA0 + {4'h0, start + 4'(i)});

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_a = ($urandom_range(99) != 0);
            if (!hv_a || last_hs) ha_a = 4'($urandom_range(15));
            hv_a  = ($urandom_range(3) != 0);
            rar_a = ($urandom_range(3) != 0);
            pr_a  = $urandom_range(1);
            step_a();
        end
        rst_a = 1'b1;
        hv_a = 1'b0; pr_a = 1'b1;
        repeat (6) step_a();
        chk("final_occupancy", occ_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
